// File: rtl/smiley_move_ctrl_if.sv
// Smiley motion controller bus: frame/collision/key inputs and sprite position/busy outputs.
// master drives the inputs (frame logic, collision detector, keys); slave is the controller.
interface smiley_move_ctrl_if;
  logic        startOfFrame;
  logic        collision;
  logic [3:0]  HitEdgeCode;
  logic        toggleX;
  logic [10:0] topLeftX;
  logic [10:0] topLeftY;
  logic        busy;

  modport master (
    output startOfFrame, collision, HitEdgeCode, toggleX,
    input  topLeftX, topLeftY, busy
  );

  modport slave (
    input  startOfFrame, collision, HitEdgeCode, toggleX,
    output topLeftX, topLeftY, busy
  );
endinterface

// File: rtl/smiley_move_ctrl.sv
// Smiley sprite per-frame motion: bounce, optional gravity (GRAVITY_EN), move, clamp to screen.
// Position valid 3 cycles after startOfFrame (4 with GRAVITY_EN); no backpressure, inputs sampled every cycle.
module smiley_move_ctrl #(
  parameter int INITIAL_X       = 280,
  parameter int INITIAL_Y       = 185,
  parameter int INITIAL_X_SPEED = 40,
  parameter int INITIAL_Y_SPEED = 20,
  parameter int FP_BITS         = 6,
  parameter int SCREEN_W        = 640,
  parameter int SCREEN_H        = 480,
  parameter int OBJ_W           = 32,
  parameter int OBJ_H           = 32
`ifdef GRAVITY_EN
  ,
  parameter int Y_ACCEL         = 1,
  parameter int MAX_Y_SPEED     = 230
`endif
) (
  input  logic               clk,
  input  logic               resetN,
  smiley_move_ctrl_if.slave  bus
);

`ifdef GRAVITY_EN
  typedef enum logic [2:0] {S_IDLE, S_BOUNCE, S_GRAVITY, S_MOVE, S_LIMIT} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_BOUNCE, S_MOVE, S_LIMIT} state_t;
`endif

  localparam logic signed [17:0] X_MAX_PX  = 18'(SCREEN_W - OBJ_W);
  localparam logic signed [17:0] Y_MAX_PX  = 18'(SCREEN_H - OBJ_H);
  localparam logic signed [17:0] X_MAX_FP  = 18'((SCREEN_W - OBJ_W) << FP_BITS);
  localparam logic signed [17:0] Y_MAX_FP  = 18'((SCREEN_H - OBJ_H) << FP_BITS);
  localparam logic signed [17:0] X_RST_FP  = 18'(INITIAL_X << FP_BITS);
  localparam logic signed [17:0] Y_RST_FP  = 18'(INITIAL_Y << FP_BITS);
  localparam logic signed [11:0] X_RST_SPD = 12'(INITIAL_X_SPEED);
  localparam logic signed [11:0] Y_RST_SPD = 12'(INITIAL_Y_SPEED);

  state_t             state, state_nxt;
  logic signed [17:0] x_pos_fp, y_pos_fp, x_pos_nxt, y_pos_nxt;
  logic signed [11:0] x_speed, y_speed, x_spd_nxt, y_spd_nxt;
  logic [3:0]         hit_latch, hit_nxt;
  logic               toggle_pend, tog_nxt;
  logic [10:0]        top_x_nxt, top_y_nxt;

  logic               x_flip, y_flip;
  logic signed [17:0] x_px, y_px;
  logic signed [11:0] x_abs, y_abs;

  // A pending key toggle inverts whatever the bounce decided, so hit+toggle cancels out.
  assign x_flip = ((hit_latch[3] && x_speed[11]) ||
                   (hit_latch[1] && !x_speed[11] && (x_speed != '0))) ^ toggle_pend;
  assign y_flip = (hit_latch[2] && y_speed[11]) ||
                  (hit_latch[0] && !y_speed[11] && (y_speed != '0));

  assign x_px  = x_pos_fp >>> FP_BITS;
  assign y_px  = y_pos_fp >>> FP_BITS;
  assign x_abs = x_speed[11] ? -x_speed : x_speed;
  assign y_abs = y_speed[11] ? -y_speed : y_speed;

`ifdef GRAVITY_EN
  localparam logic signed [12:0] Y_SAT = 13'(MAX_Y_SPEED);
  logic signed [12:0] y_acc;
  logic signed [11:0] y_grav;
  assign y_acc  = {y_speed[11], y_speed} + 13'(Y_ACCEL);
  assign y_grav = (y_acc > Y_SAT) ? Y_SAT[11:0] : y_acc[11:0];
`endif

  always_comb begin
    state_nxt = state;
    x_pos_nxt = x_pos_fp;
    y_pos_nxt = y_pos_fp;
    x_spd_nxt = x_speed;
    y_spd_nxt = y_speed;
    top_x_nxt = bus.topLeftX;
    top_y_nxt = bus.topLeftY;
    hit_nxt   = bus.collision ? (hit_latch | bus.HitEdgeCode) : hit_latch;
    tog_nxt   = toggle_pend | bus.toggleX;
    case (state)
      S_IDLE: begin
        if (bus.startOfFrame) state_nxt = S_BOUNCE;
      end
      S_BOUNCE: begin
        x_spd_nxt = x_flip ? -x_speed : x_speed;
        y_spd_nxt = y_flip ? -y_speed : y_speed;
        // This frame's hits are consumed; a hit on this very cycle starts the next frame's latch.
        hit_nxt   = bus.collision ? bus.HitEdgeCode : 4'b0000;
        tog_nxt   = bus.toggleX;
`ifdef GRAVITY_EN
        state_nxt = S_GRAVITY;
`else
        state_nxt = S_MOVE;
`endif
      end
`ifdef GRAVITY_EN
      S_GRAVITY: begin
        y_spd_nxt = y_grav;
        state_nxt = S_MOVE;
      end
`endif
      S_MOVE: begin
        x_pos_nxt = x_pos_fp + {{6{x_speed[11]}}, x_speed};
        y_pos_nxt = y_pos_fp + {{6{y_speed[11]}}, y_speed};
        state_nxt = S_LIMIT;
      end
      S_LIMIT: begin
        top_x_nxt = x_px[10:0];
        top_y_nxt = y_px[10:0];
        if (x_px[17]) begin
          x_pos_nxt = '0;
          x_spd_nxt = x_abs;
          top_x_nxt = '0;
        end else if (x_px > X_MAX_PX) begin
          x_pos_nxt = X_MAX_FP;
          x_spd_nxt = -x_abs;
          top_x_nxt = X_MAX_PX[10:0];
        end
        if (y_px[17]) begin
          y_pos_nxt = '0;
          y_spd_nxt = y_abs;
          top_y_nxt = '0;
        end else if (y_px > Y_MAX_PX) begin
          y_pos_nxt = Y_MAX_FP;
          y_spd_nxt = -y_abs;
          top_y_nxt = Y_MAX_PX[10:0];
        end
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= S_IDLE;
      x_pos_fp     <= X_RST_FP;
      y_pos_fp     <= Y_RST_FP;
      x_speed      <= X_RST_SPD;
      y_speed      <= Y_RST_SPD;
      hit_latch    <= '0;
      toggle_pend  <= 1'b0;
      bus.topLeftX <= 11'(INITIAL_X);
      bus.topLeftY <= 11'(INITIAL_Y);
      bus.busy     <= 1'b0;
    end else begin
      state        <= state_nxt;
      x_pos_fp     <= x_pos_nxt;
      y_pos_fp     <= y_pos_nxt;
      x_speed      <= x_spd_nxt;
      y_speed      <= y_spd_nxt;
      hit_latch    <= hit_nxt;
      toggle_pend  <= tog_nxt;
      bus.topLeftX <= top_x_nxt;
      bus.topLeftY <= top_y_nxt;
      bus.busy     <= (state_nxt != S_IDLE);
    end
  end

endmodule

// File: tb/tb_smiley_move_ctrl.sv
// Randomized scoreboard bench for smiley_move_ctrl: two instances (default and edge-clamping
// parameters) share stimulus; a frame-level model predicts each frame's position.
`timescale 1ns/1ps
module tb_smiley_move_ctrl;
  localparam int FP = 64;
  localparam int XMAX = 608;
  localparam int YMAX = 448;
`ifdef GRAVITY_EN
  localparam int BUSY_LEN = 4;
`else
  localparam int BUSY_LEN = 3;
`endif

  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  smiley_move_ctrl_if if0();
  smiley_move_ctrl_if if1();

  smiley_move_ctrl dut0 (.clk(clk), .resetN(resetN), .bus(if0));
  smiley_move_ctrl #(.INITIAL_X(600), .INITIAL_Y(10), .INITIAL_X_SPEED(640), .INITIAL_Y_SPEED(-700))
    dut1 (.clk(clk), .resetN(resetN), .bus(if1));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {int x; int y;} pos_t;
  pos_t q0[$];
  pos_t q1[$];

  int         m_x[2], m_y[2], m_xs[2], m_ys[2];
  logic [3:0] m_hit[2];
  bit         m_tog[2];

  function automatic int fdiv(input int v);
    return (v >= 0) ? v / FP : -((-v + FP - 1) / FP);
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic m_reset();
    m_x[0] = 280 * FP; m_y[0] = 185 * FP; m_xs[0] = 40;  m_ys[0] = 20;
    m_x[1] = 600 * FP; m_y[1] = 10 * FP;  m_xs[1] = 640; m_ys[1] = -700;
    for (int d = 0; d < 2; d++) begin
      m_hit[d] = 4'b0000;
      m_tog[d] = 1'b0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic m_idle(input bit col, input logic [3:0] code, input bit tog);
    for (int d = 0; d < 2; d++) begin
      if (col) m_hit[d] = m_hit[d] | code;
      if (tog) m_tog[d] = 1'b1;
    end
  endtask

  // One whole frame update: bounce, gravity, move, clamp; then the bounce-cycle inputs restart the latches.
  task automatic m_frame(input bit bcol, input logic [3:0] bcode, input bit btog);
    for (int d = 0; d < 2; d++) begin
      int   px, py;
      pos_t e;
      if ((m_hit[d][3] && m_xs[d] < 0) || (m_hit[d][1] && m_xs[d] > 0)) m_xs[d] = -m_xs[d];
      if ((m_hit[d][2] && m_ys[d] < 0) || (m_hit[d][0] && m_ys[d] > 0)) m_ys[d] = -m_ys[d];
      if (m_tog[d]) m_xs[d] = -m_xs[d];
`ifdef GRAVITY_EN
      m_ys[d] = (m_ys[d] + 1 > 230) ? 230 : m_ys[d] + 1;
`endif
      m_x[d] += m_xs[d];
      m_y[d] += m_ys[d];
      px = fdiv(m_x[d]);
      py = fdiv(m_y[d]);
      if (px < 0) begin
        px = 0; m_x[d] = 0; m_xs[d] = iabs(m_xs[d]);
      end else if (px > XMAX) begin
        px = XMAX; m_x[d] = XMAX * FP; m_xs[d] = -iabs(m_xs[d]);
      end
      if (py < 0) begin
        py = 0; m_y[d] = 0; m_ys[d] = iabs(m_ys[d]);
      end else if (py > YMAX) begin
        py = YMAX; m_y[d] = YMAX * FP; m_ys[d] = -iabs(m_ys[d]);
      end
      e.x = px;
      e.y = py;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
      m_hit[d] = bcol ? bcode : 4'b0000;
      m_tog[d] = btog;
    end
  endtask

  task automatic drive(input bit sof, input bit col, input logic [3:0] code, input bit tog);
    @(negedge clk);
    if0.startOfFrame = sof; if0.collision = col; if0.HitEdgeCode = code; if0.toggleX = tog;
    if1.startOfFrame = sof; if1.collision = col; if1.HitEdgeCode = code; if1.toggleX = tog;
  endtask

  task automatic rnd_in(input bit rnd, output bit col, output logic [3:0] code, output bit tog);
    col  = rnd && ($urandom_range(0, 7) == 0);
    code = rnd ? 4'($urandom_range(0, 15)) : 4'b0000;
    tog  = rnd && ($urandom_range(0, 29) == 0);
  endtask

  task automatic idle(input int n, input bit rnd);
    bit c, t;
    logic [3:0] k;
    for (int i = 0; i < n; i++) begin
      rnd_in(rnd, c, k, t);
      drive(1'b0, c, k, t);
      m_idle(c, k, t);
    end
  endtask

  // Returns one cycle after the position update, with inputs idle.
  task automatic run_frame(input bit rnd, input bit btog);
    bit c, t, s;
    logic [3:0] k;
    rnd_in(rnd, c, k, t);
    drive(1'b1, c, k, t);
    m_idle(c, k, t);
    rnd_in(rnd, c, k, t);
    t = t | btog;
    drive(1'b0, c, k, t);
    m_frame(c, k, t);
    for (int i = 1; i < BUSY_LEN; i++) begin
      rnd_in(rnd, c, k, t);
      s = rnd && ($urandom_range(0, 3) == 0);
      drive(s, c, k, t);
      m_idle(c, k, t);
    end
    drive(1'b0, 1'b0, 4'b0000, 1'b0);
  endtask

  bit prev_b[2];
  int blen[2];

  task automatic mon_step(input int d, input logic b, input logic [10:0] x, input logic [10:0] y);
    pos_t e;
    if (b) blen[d]++;
    if (!b && prev_b[d]) begin
      check($sformatf("busy_len%0d", d), blen[d], BUSY_LEN);
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow%0d: frame completed with no expected entry", d);
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("sb_x%0d", d), int'(x), e.x);
        check($sformatf("sb_y%0d", d), int'(y), e.y);
      end
      blen[d] = 0;
    end
    prev_b[d] = b;
  endtask

  always @(negedge clk) begin
    if (!resetN) begin
      for (int d = 0; d < 2; d++) begin
        prev_b[d] = 1'b0;
        blen[d]   = 0;
      end
    end else begin
      mon_step(0, if0.busy, if0.topLeftX, if0.topLeftY);
      mon_step(1, if1.busy, if1.topLeftX, if1.topLeftY);
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_x0"}, int'(if0.topLeftX), 280);
    check({tag, "_y0"}, int'(if0.topLeftY), 185);
    check({tag, "_busy0"}, int'(if0.busy), 0);
    check({tag, "_x1"}, int'(if1.topLeftX), 600);
    check({tag, "_y1"}, int'(if1.topLeftY), 10);
    check({tag, "_busy1"}, int'(if1.busy), 0);
  endtask

  initial begin
    resetN = 1'b0;
    if0.startOfFrame = 0; if0.collision = 0; if0.HitEdgeCode = 4'b0; if0.toggleX = 0;
    if1.startOfFrame = 0; if1.collision = 0; if1.HitEdgeCode = 4'b0; if1.toggleX = 0;
    m_reset();
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    @(negedge clk);
    resetN = 1'b1;

    idle(1000, 1'b0);
    check("quiet_x0", int'(if0.topLeftX), 280);
    check("quiet_y0", int'(if0.topLeftY), 185);

    // Free motion, one frame per ~1000 cycles
    for (int f = 0; f < 16; f++) begin
      idle(995, 1'b0);
      run_frame(1'b0, 1'b0);
      if (f == 0) check("clamp_hi_x1", int'(if1.topLeftX), 608);
      if (f == 1) check("clamp_back_x1", int'(if1.topLeftX), 598);
    end
    check("free_x0", int'(if0.topLeftX), 290);
`ifndef GRAVITY_EN
    check("free_y0", int'(if0.topLeftY), 190);
`endif

    // Right hit reverses +X; toggle with a hit cancels; toggle during bounce lands next frame; Left hit
    drive(1'b0, 1'b1, 4'b0010, 1'b0); m_idle(1'b1, 4'b0010, 1'b0);
    run_frame(1'b0, 1'b0);
    idle(15, 1'b0);
    drive(1'b0, 1'b1, 4'b0010, 1'b1); m_idle(1'b1, 4'b0010, 1'b1);
    run_frame(1'b0, 1'b0);
    idle(10, 1'b0);
    run_frame(1'b0, 1'b1);
    idle(10, 1'b0);
    run_frame(1'b0, 1'b0);
    drive(1'b0, 1'b1, 4'b1000, 1'b0); m_idle(1'b1, 4'b1000, 1'b0);
    run_frame(1'b0, 1'b0);

    repeat (150) begin
      idle($urandom_range(2, 40), 1'b1);
      run_frame(1'b1, 1'b0);
    end

    // Reset in the middle of a frame update
    idle(5, 1'b0);
    drive(1'b1, 1'b0, 4'b0000, 1'b0); m_idle(1'b0, 4'b0000, 1'b0);
    drive(1'b0, 1'b0, 4'b0000, 1'b0); m_frame(1'b0, 4'b0000, 1'b0);
    @(negedge clk);
    #2 resetN = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    check_reset_vals("midreset");
    resetN = 1'b1;

    repeat (30) begin
      idle($urandom_range(2, 40), 1'b1);
      run_frame(1'b1, 1'b0);
    end
    idle(10, 1'b0);
    check("sb_left0", q0.size(), 0);
    check("sb_left1", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
